// File: rtl/jk_cnt_pkg.sv
// ---------------------------------------------------------------------------
// jk_cnt_pkg
// Shared types and helpers for the JK-cell modulo counter.
//   state_e   : controller states (idle / running / one-shot finished)
//   JK_*      : two-bit {J,K} commands driven into each jk_cell
//   gray_of() : binary-to-Gray conversion, sized for up to GRAY_MAX_W bits
// ---------------------------------------------------------------------------
package jk_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // {J,K} pairs as seen by a single JK flip-flop
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  localparam int GRAY_MAX_W = 32;

  // Callers cast their WIDTH-bit value up to GRAY_MAX_W and the result back down
  function automatic logic [GRAY_MAX_W-1:0] gray_of(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
// One JK flip-flop with an asynchronous, active-high reset to RST_VAL.
// Ports:
//   clk_flipflop    in  : clock, rising edge
//   reset_flipflop  in  : asynchronous active-high reset, forces q_o = RST_VAL
//   j_i, k_i        in  : JK command (00 hold, 01 reset, 10 set, 11 toggle)
//   q_o             out : stored bit
// ---------------------------------------------------------------------------
module jk_cell
  import jk_cnt_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_flipflop,
  input  logic reset_flipflop,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  // Classic JK truth table
  always_ff @(posedge clk_flipflop or posedge reset_flipflop) begin
    if (reset_flipflop) begin
      q_q <= RST_VAL;
    end else begin
      case ({j_i, k_i})
        JK_RST:  q_q <= 1'b0;
        JK_SET:  q_q <= 1'b1;
        JK_TGL:  q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// ---------------------------------------------------------------------------
// jk_mod_counter
// Synchronous modulo-MODULUS up/down counter built from WIDTH jk_cell
// instances sharing one clock, plus a small run controller (idle / run /
// one-shot done) with parallel load and a one-cycle terminal-count pulse.
//
// Parameters: WIDTH (>=2), MODULUS (2..2**WIDTH), RESET_VAL (< MODULUS)
// Ports:
//   clk_flipflop    in         : clock, rising edge
//   reset_flipflop  in         : asynchronous active-high reset
//   en              in         : count enable while running
//   up_dn           in         : 1 = up, 0 = down
//   start           in         : idle/done -> run, latches one_shot
//   one_shot        in         : 1 = stop at terminal, 0 = wrap
//   load            in         : parallel load of load_val (clamped to MODULUS-1)
//   load_val        in [WIDTH] : value for load
//   count           out[WIDTH] : current count
//   tc              out        : terminal-count pulse
//   busy            out        : controller is running
//   done            out        : one-shot run has finished
//   count_gray      out[WIDTH] : Gray code of count (only with JKCNT_GRAY_OUT_EN)
//
// Build option: define JKCNT_GRAY_OUT_EN to add the registered count_gray port.
// ---------------------------------------------------------------------------
module jk_mod_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int MODULUS   = 32,
  parameter int RESET_VAL = MODULUS - 1
) (
  input  logic             clk_flipflop,
  input  logic             reset_flipflop,
  input  logic             en,
  input  logic             up_dn,
  input  logic             start,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
`ifdef JKCNT_GRAY_OUT_EN
  output logic             done,
  output logic [WIDTH-1:0] count_gray
`else
  output logic             done
`endif
);

  localparam logic [WIDTH-1:0] TERM_UP   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic                  tc_q, tc_d;
  logic                  busy_q, done_q;
  logic [WIDTH-1:0]      count_q;
  logic [WIDTH-1:0]      stepValue;
  logic [WIDTH-1:0]      toggleEn;
  logic [WIDTH-1:0]      loadValue;
  logic [WIDTH-1:0][1:0] jkCmd;
  logic                  doLoad, doStep, atTerminal, canStart;

  // The bits that flip on a +/-1 step are exactly the toggle enables of a
  // synchronous binary counter (carry/borrow chain).
  assign stepValue = up_dn ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
  assign toggleEn  = count_q ^ stepValue;

  // Controller: load wins over start, start wins over stepping. Wrap-around
  // is done through the load path because MODULUS need not be a power of two.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tc_d       = 1'b0;
    doLoad     = 1'b0;
    doStep     = 1'b0;
    loadValue  = count_q;
    canStart   = start && (state_q != ST_RUN);
    atTerminal = up_dn ? (count_q == TERM_UP) : (count_q == '0);

    if (load) begin
      doLoad    = 1'b1;
      loadValue = ({1'b0, load_val} >= MOD_EXT) ? TERM_UP : load_val;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
      if (canStart) begin
        state_d = ST_RUN;
        mode_d  = one_shot;
      end
    end else if (canStart) begin
      state_d = ST_RUN;
      mode_d  = one_shot;
    end else if ((state_q == ST_RUN) && en) begin
      if (atTerminal) begin
        tc_d = 1'b1;
        if (mode_q) begin
          state_d = ST_DONE;
        end else begin
          doLoad    = 1'b1;
          loadValue = up_dn ? '0 : TERM_UP;
        end
      end else begin
        doStep = 1'b1;
      end
    end
  end

  // Per-bit JK commands: J=d/K=~d for loads, toggle enables for steps
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      jkCmd[i] = JK_HOLD;
      if (doLoad) begin
        jkCmd[i] = loadValue[i] ? JK_SET : JK_RST;
      end else if (doStep) begin
        jkCmd[i] = toggleEn[i] ? JK_TGL : JK_HOLD;
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : gCell
    jk_cell #(
      .RST_VAL(RST_COUNT[g])
    ) uCell (
      .clk_flipflop  (clk_flipflop),
      .reset_flipflop(reset_flipflop),
      .j_i           (jkCmd[g][1]),
      .k_i           (jkCmd[g][0]),
      .q_o           (count_q[g])
    );
  end

  // Controller state and registered status flags
  always_ff @(posedge clk_flipflop or posedge reset_flipflop) begin
    if (reset_flipflop) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef JKCNT_GRAY_OUT_EN
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] gray_q;

  // Gray register is fed from the next count so it lines up with count
  always_comb begin
    count_d = count_q;
    if (doLoad) begin
      count_d = loadValue;
    end else if (doStep) begin
      count_d = stepValue;
    end
  end

  always_ff @(posedge clk_flipflop or posedge reset_flipflop) begin
    if (reset_flipflop) begin
      gray_q <= WIDTH'(gray_of(GRAY_MAX_W'(RST_COUNT)));
    end else begin
      gray_q <= WIDTH'(gray_of(GRAY_MAX_W'(count_d)));
    end
  end

  assign count_gray = gray_q;
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_mod_counter
// Drives two counters from the same inputs: one with default parameters
// (WIDTH 5, MODULUS 32) and one with MODULUS 10. Directed vector table,
// hand-written reset and Gray sequences, then random traffic against a
// behavioural model of the MODULUS-10 counter.
// Build option JKCNT_GRAY_OUT_EN enables the count_gray checks.
// ---------------------------------------------------------------------------
module tb_jk_mod_counter;

  localparam int W      = 5;
  localparam int MOD    = 10;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk;
  logic         rst;
  logic         en, upDn, start, oneShot, load;
  logic [W-1:0] loadVal;
  logic [W-1:0] cntDef, cntMod;
  logic         tcDef, busyDef, doneDef;
  logic         tcMod, busyMod, doneMod;
`ifdef JKCNT_GRAY_OUT_EN
  logic [W-1:0] grayDef, grayMod;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit           ld, st, os, en, up;
    logic [W-1:0] lv;
    logic [W-1:0] expCount;
    bit           expTc, expBusy, expDone;
    string        name;
  } vec_t;

  vec_t vecs[$];

  int mCount;
  int mState;
  bit mMode;
  bit mTc;

  jk_mod_counter uDutDef (
    .clk_flipflop  (clk),
    .reset_flipflop(rst),
    .en            (en),
    .up_dn         (upDn),
    .start         (start),
    .one_shot      (oneShot),
    .load          (load),
    .load_val      (loadVal),
    .count         (cntDef),
    .tc            (tcDef),
    .busy          (busyDef),
`ifdef JKCNT_GRAY_OUT_EN
    .done          (doneDef),
    .count_gray    (grayDef)
`else
    .done          (doneDef)
`endif
  );

  jk_mod_counter #(
    .WIDTH  (W),
    .MODULUS(MOD)
  ) uDutMod (
    .clk_flipflop  (clk),
    .reset_flipflop(rst),
    .en            (en),
    .up_dn         (upDn),
    .start         (start),
    .one_shot      (oneShot),
    .load          (load),
    .load_val      (loadVal),
    .count         (cntMod),
    .tc            (tcMod),
    .busy          (busyMod),
`ifdef JKCNT_GRAY_OUT_EN
    .done          (doneMod),
    .count_gray    (grayMod)
`else
    .done          (doneMod)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model of the MODULUS-10 counter, one call per rising edge
  function automatic void modelReset();
    mCount = MOD - 1;
    mState = M_IDLE;
    mMode  = 1'b0;
    mTc    = 1'b0;
  endfunction

  function automatic void modelEdge(bit ld, bit st, bit os, bit e, bit up, int lv);
    bit startOk;
    startOk = st && (mState != M_RUN);
    mTc     = 1'b0;
    if (ld) begin
      mCount = (lv >= MOD) ? MOD - 1 : lv;
      if (mState == M_DONE) mState = M_IDLE;
    end
    if (startOk) begin
      mState = M_RUN;
      mMode  = os;
    end else if (!ld && mState == M_RUN && e) begin
      if ((up && mCount == MOD - 1) || (!up && mCount == 0)) begin
        mTc = 1'b1;
        if (mMode) mState = M_DONE;
        else mCount = up ? 0 : MOD - 1;
      end else begin
        mCount = (mCount + (up ? 1 : MOD - 1)) % MOD;
      end
    end
  endfunction

  function automatic logic [31:0] modelPack();
    return 32'({W'(mCount), mTc, (mState == M_RUN), (mState == M_DONE)});
  endfunction

  function automatic logic [31:0] packMod();
    return 32'({cntMod, tcMod, busyMod, doneMod});
  endfunction

  function automatic logic [31:0] packDef();
    return 32'({cntDef, tcDef, busyDef, doneDef});
  endfunction

  function automatic logic [31:0] packExp(int c, bit t, bit b, bit d);
    return 32'({W'(c), t, b, d});
  endfunction

  function automatic void addRow(bit ld, bit st, bit os, bit e, bit up, int lv,
                                 int c, bit t, bit b, bit d, string n);
    vec_t v;
    v.ld = ld; v.st = st; v.os = os; v.en = e; v.up = up;
    v.lv = W'(lv);
    v.expCount = W'(c);
    v.expTc = t; v.expBusy = b; v.expDone = d;
    v.name = n;
    vecs.push_back(v);
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are compared there too
  task automatic applyStimulus(input bit ld, input bit st, input bit os,
                               input bit e, input bit up, input logic [W-1:0] lv);
    load = ld; start = st; oneShot = os; en = e; upDn = up; loadVal = lv;
    @(posedge clk);
    modelEdge(ld, st, os, e, up, int'(lv));
    #1;
  endtask

  // Packed compare: {count, tc, busy, done}
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got {count,tc,busy,done}=%0h expected %0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic pulseReset();
    load = 0; start = 0; en = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    bit dir;

    // Directed vectors for the MODULUS-10 counter, starting from reset (9, idle)
    addRow(1,0,0,0,1,12, 9,0,0,0, "clampIdle");
    addRow(1,1,1,1,0,3,  3,0,1,0, "loadStartOneShot");
    for (int k = 2; k >= 0; k--) addRow(0,0,1,1,0,0, k,0,1,0, "downStep");
    addRow(0,0,1,1,0,0, 0,1,0,1, "oneShotTerminal");
    addRow(0,0,0,1,0,0, 0,0,0,1, "doneHold");
    addRow(0,1,1,1,0,0, 0,0,1,0, "restartFromDone");
    addRow(0,0,0,1,0,0, 0,1,0,1, "terminalAgain");
    addRow(1,0,0,1,1,0, 0,0,0,0, "loadInDone");
    addRow(0,1,0,1,1,0, 0,0,1,0, "startFreeRun");
    for (int lap = 0; lap < 2; lap++) begin
      for (int k = 1; k < MOD; k++) addRow(0,0,0,1,1,0, k,0,1,0, "upStep");
      addRow(0,0,0,1,1,0, 0,1,1,0, "wrapTc");
    end
    for (int k = 1; k <= 5; k++) addRow(0,0,0,1,1,0, k,0,1,0, "upStep2");
    addRow(1,0,0,1,1,4, 4,0,1,0, "loadInRun");
    addRow(0,0,0,1,1,0, 5,0,1,0, "enOn");
    addRow(0,0,0,0,1,0, 5,0,1,0, "enOff1");
    addRow(0,0,0,0,1,0, 5,0,1,0, "enOff2");
    addRow(0,0,0,1,1,0, 6,0,1,0, "enOnAgain");
    addRow(0,0,0,1,0,0, 5,0,1,0, "flipDown1");
    addRow(0,0,0,1,0,0, 4,0,1,0, "flipDown2");

    rst = 1'b1;
    load = 0; start = 0; oneShot = 0; en = 0; upDn = 1; loadVal = '0;
    #12;
    modelReset();
    checkOutput("resetDefault", packDef(), packExp(31,0,0,0));
    checkOutput("resetMod", packMod(), packExp(MOD-1,0,0,0));
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ld, vecs[i].st, vecs[i].os, vecs[i].en, vecs[i].up, vecs[i].lv);
      checkOutput(vecs[i].name, packMod(),
                  packExp(int'(vecs[i].expCount), vecs[i].expTc, vecs[i].expBusy, vecs[i].expDone));
    end

    // Asynchronous reset in the middle of a run on the default counter
    pulseReset();
    applyStimulus(1,1,0,0,1,5'd7);
    checkOutput("runAt7", packDef(), packExp(7,0,1,0));
    #3 rst = 1'b1;
    #1;
    checkOutput("asyncResetDefault", packDef(), packExp(31,0,0,0));
    checkOutput("asyncResetMod", packMod(), packExp(MOD-1,0,0,0));
    #2 rst = 1'b0;
    modelReset();
    applyStimulus(0,0,0,1,1,5'd0);
    checkOutput("idleAfterReset", packDef(), packExp(31,0,0,0));

`ifdef JKCNT_GRAY_OUT_EN
    // Full sweep of the default counter with its Gray output
    pulseReset();
    applyStimulus(1,1,0,1,1,5'd0);
    for (int k = 0; k <= 32; k++) begin
      int c;
      c = k % 32;
      checkOutput("graySweepCount", 32'(cntDef), 32'(c));
      checkOutput("graySweepCode", 32'(grayDef), 32'(c ^ (c >> 1)));
      applyStimulus(0,0,0,1,1,5'd0);
    end
`endif

    // Random traffic against the model
    pulseReset();
    dir = 1'b1;
    for (int n = 0; n < 400; n++) begin
      bit rl, rs, ro, re;
      logic [W-1:0] rv;
      rl = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 7) == 0);
      ro = $urandom_range(0, 1) == 1;
      re = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      rv = W'($urandom_range(0, 31));
      applyStimulus(rl, rs, ro, re, dir, rv);
      checkOutput("random", packMod(), modelPack());
`ifdef JKCNT_GRAY_OUT_EN
      checkOutput("randomGray", 32'(grayMod), 32'(mCount ^ (mCount >> 1)));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
